// File: rtl/hv_fold_scheduler.sv
// hv_fold_scheduler: sequences one feature frame through the folded HV
// datapath (feature latch, fold 0..NUM_FOLDS-1, completed-frame token) and
// enables the associative memory once WARMUP_FRAMES frames have been encoded.
// Optional stall/frame statistics are compiled in with HV_FOLD_STALL_STATS_EN.
module hv_fold_scheduler #(
    parameter int NUM_FOLDS       = 4,
    parameter int NUM_FOLDS_WIDTH = $clog2(NUM_FOLDS),
    parameter int WARMUP_FRAMES   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fin_valid,
    output logic                       fin_ready,
    output logic                       feat_load,
    output logic                       fold_valid,
    input  logic                       fold_ready,
    output logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
    output logic                       fold_last,
    output logic                       frame_valid,
    input  logic                       frame_ready,
`ifdef HV_FOLD_STALL_STATS_EN
    output logic [15:0]                stall_cycles,
    output logic [15:0]                frame_count,
`endif
    output logic                       am_en,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_IDX = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
    localparam logic [7:0]                 WARM_TGT = 8'(WARMUP_FRAMES);

    state_e                       r_state;
    state_e                       w_next_state;
    logic                         r_feat_load;
    logic                         r_fold_valid;
    logic [NUM_FOLDS_WIDTH-1:0]   r_fold_idx;
    logic                         r_frame_valid;
    logic                         r_am_en;
    logic                         r_busy;
    logic [7:0]                   r_warm_cnt;

    logic                         w_fold_hs;
    logic                         w_frame_hs;
    logic                         w_at_last;

    // fold_valid is only ever high in FOLD, so fold_ready elsewhere is inert;
    // the same holds for frame_ready outside DONE.
    assign w_fold_hs  = r_fold_valid && fold_ready;
    assign w_frame_hs = r_frame_valid && frame_ready;
    assign w_at_last  = (r_fold_idx == LAST_IDX);

    // No frame can be accepted while the block is held in reset.
    assign fin_ready   = (r_state == S_IDLE) && rst;
    assign fold_last   = r_fold_valid && w_at_last;
    assign feat_load   = r_feat_load;
    assign fold_valid  = r_fold_valid;
    assign fold_idx    = r_fold_idx;
    assign frame_valid = r_frame_valid;
    assign am_en       = r_am_en;
    assign busy        = r_busy;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment first guarantees no latch on any path.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (fin_valid)               w_next_state = S_LOAD;
            S_LOAD:                              w_next_state = S_FOLD;
            S_FOLD: if (w_fold_hs && w_at_last)  w_next_state = S_DONE;
            S_DONE: if (w_frame_hs)              w_next_state = S_IDLE;
            default:                             w_next_state = S_IDLE;
        endcase
    end

    // Registered handshake/strobe outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_feat_load   <= 1'b0;
            r_fold_valid  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_feat_load   <= (w_next_state == S_LOAD);
            r_fold_valid  <= (w_next_state == S_FOLD);
            r_frame_valid <= (w_next_state == S_DONE);
            r_busy        <= (w_next_state != S_IDLE);
        end
    end

    // Fold index: cleared on load, advances per fold handshake, wraps after the last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fold_idx <= '0;
        end else if (r_state == S_LOAD) begin
            r_fold_idx <= '0;
        end else if (r_state == S_FOLD && w_fold_hs) begin
            r_fold_idx <= w_at_last ? '0 : r_fold_idx + 1'b1;
        end
    end

    // Warmup counter saturates at the target; am_en is sticky once reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_warm_cnt <= 8'd0;
            r_am_en    <= 1'b0;
        end else if (w_frame_hs) begin
            if (r_warm_cnt < WARM_TGT) begin
                r_warm_cnt <= r_warm_cnt + 8'd1;
            end
            if (r_warm_cnt + 8'd1 >= WARM_TGT) begin
                r_am_en <= 1'b1;
            end
        end
    end

`ifdef HV_FOLD_STALL_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_frame_count;
    logic        w_stall;

    // A stall is any cycle where this block offers data nobody takes.
    assign w_stall      = (r_fold_valid && !fold_ready) || (r_frame_valid && !frame_ready);
    assign stall_cycles = r_stall_cycles;
    assign frame_count  = r_frame_count;

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 16'd0;
            r_frame_count  <= 16'd0;
        end else begin
            if (w_stall && r_stall_cycles != 16'hFFFF) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_frame_hs && r_frame_count != 16'hFFFF) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end
`endif

endmodule
